// File: rtl/lut_neuron_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lut_neuron_pkg                                               |
// | Description : Shared types and sizing for the runtime-loadable LUT neuron  |
// |               block: FSM state enum, default geometry, counter width.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lut_neuron_pkg;

  localparam int FAN_IN_DEF      = 6;
  localparam int OUT_BITS_DEF    = 1;
  localparam int NUM_NEURONS_DEF = 4;

  localparam int DEPTH = 2 ** FAN_IN_DEF;
  localparam int TOTAL = NUM_NEURONS_DEF * DEPTH;
  localparam int CNT_W = $clog2(TOTAL);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  // Entry counter width for an arbitrary geometry; never below 1 bit.
  function automatic int cnt_width(input int fan_in, input int neurons);
    int total;
    total = neurons * (2 ** fan_in);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_neuron_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lut_neuron_loader_if                                         |
// | Description : Config stream and lookup bus of the LUT neuron loader.       |
// |               master = host/datapath side, slave = loader block.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface lut_neuron_loader_if #(
  parameter int FAN_IN      = 6,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 4
);

  logic                            cfg_start;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [OUT_BITS-1:0]             cfg_data;
  logic                            cfg_last;
  logic                            loaded;
  logic                            cfg_err;
  logic                            in_valid;
  logic [NUM_NEURONS*FAN_IN-1:0]   in_addr;
  logic                            out_valid;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_addr,
    input  cfg_ready, loaded, cfg_err, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_addr,
    output cfg_ready, loaded, cfg_err, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/lut_neuron_loader_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lut_neuron_ram                                               |
// | Description : One neuron truth table: 2**ADDR_W x DATA_W distributed RAM,  |
// |               synchronous write, asynchronous read, no reset.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lut_neuron_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Table entry write; contents are only meaningful after a complete load.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/lut_neuron_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lut_neuron_loader                                            |
// | Description : Streams a truth table into per-neuron RAMs, then serves      |
// |               registered lookups (M0 in -> M1 out one cycle later).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lut_neuron_loader
  import lut_neuron_pkg::*;
#(
  parameter int FAN_IN      = FAN_IN_DEF,
  parameter int OUT_BITS    = OUT_BITS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  lut_neuron_loader_if.slave  bus
);

  localparam int TBL_DEPTH = 2 ** FAN_IN;
  localparam int TBL_TOTAL = NUM_NEURONS * TBL_DEPTH;
  localparam int TBL_CNT_W = cnt_width(FAN_IN, NUM_NEURONS);
  localparam int DW        = NUM_NEURONS * OUT_BITS;

  state_e                 state_q, state_d;
  logic [TBL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   loaded_q, loaded_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          out_data_q, out_data_d;

  logic                   w_cfg_ready;
  logic                   w_accept;
  logic                   w_last_entry;
  logic [DW-1:0]          w_rd_data;

  // A restart request takes priority over any entry offered in the same cycle.
  assign w_cfg_ready  = (state_q == LOAD) && !bus.cfg_start;
  assign w_accept     = bus.cfg_valid && w_cfg_ready;
  assign w_last_entry = (cnt_q == TBL_CNT_W'(TBL_TOTAL - 1));

  // Counter upper bits select the neuron, lower FAN_IN bits the table address.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic w_we;
    assign w_we = w_accept && ((cnt_q >> FAN_IN) == TBL_CNT_W'(n));

    lut_neuron_ram #(
      .ADDR_W (FAN_IN),
      .DATA_W (OUT_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (cnt_q[FAN_IN-1:0]),
      .wdata (bus.cfg_data),
      .raddr (bus.in_addr[n*FAN_IN +: FAN_IN]),
      .rdata (w_rd_data[n*OUT_BITS +: OUT_BITS])
    );
  end

  // Next-state: load sequencing, cfg_last position check, and lookup capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loaded_d    = loaded_q;
    cfg_err_d   = cfg_err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    // Lookups read the table as it stands this cycle, so a reload request
    // arriving together with a lookup still returns the old contents.
    if (state_q == READY && bus.in_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = w_rd_data;
    end

    if (bus.cfg_start) begin
      state_d   = LOAD;
      cnt_d     = '0;
      loaded_d  = 1'b0;
      cfg_err_d = 1'b0;
    end else if (w_accept) begin
      if (w_last_entry && bus.cfg_last) begin
        state_d  = READY;
        loaded_d = 1'b1;
      end else if (w_last_entry || bus.cfg_last) begin
        // Misplaced or missing end marker: the table is incomplete.
        state_d   = EMPTY;
        cfg_err_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + TBL_CNT_W'(1);
      end
    end
  end

  // State and output registers; asynchronous reset forces a full reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.loaded    = loaded_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
`default_nettype wire
